// File: rtl/mmm_seq.sv
// Self-sequencing radix-2 Montgomery multiplier: R = A*B*2^-WIDTH mod M.
// Optional operand checking is enabled with `define MMM_ERR_CHECK_EN.
module mmm_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] M,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] R
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned SW = WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SUB  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] m_q;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    cnt;

   logic             ai;
   logic             q;
   logic [SW-1:0]    sum;
   logic             bad_ops;

   // One Montgomery iteration: add ai*B, then M if needed to make the sum even.
   always_comb begin
      ai  = a_sh[0];
      q   = acc[0] ^ (ai & b_q[0]);
      sum = SW'(acc);
      if (ai) sum = sum + SW'(b_q);
      if (q)  sum = sum + SW'(m_q);
   end

`ifdef MMM_ERR_CHECK_EN
   assign bad_ops = ~M[0] | (A >= M) | (B >= M);
`else
   assign bad_ops = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         R     <= '0;
         a_sh  <= '0;
         b_q   <= '0;
         m_q   <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (ena) begin
         if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  done <= 1'b0;
                  err  <= 1'b0;
                  if (start) begin
                     if (bad_ops) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                     end else begin
                        a_sh  <= A;
                        b_q   <= B;
                        m_q   <= M;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                     end
                  end
               end
               CALC: begin
                  acc  <= AW'(sum >> 1);
                  a_sh <= a_sh >> 1;
                  cnt  <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) state <= SUB;
               end
               SUB: begin
                  // acc < 2M for legal operands, so one subtraction fully reduces
                  if (acc >= AW'(m_q)) R <= WIDTH'(acc - AW'(m_q));
                  else                 R <= WIDTH'(acc);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/mmm_seq.md
Name: mmm_seq

Overview:
- Self-sequencing radix-2 Montgomery modular multiplier: R = A*B*2^-WIDTH mod M, fully reduced to [0, M).
- Parametrised successor to the bit-serial MMM datapath.
- Internal FSM replaces external ld_a/ld_r/lock sequencing with a start/busy/done handshake, and adds a final conditional subtraction.
- Sits under the RSA exponentiation controller; one instance is reused for squarings and multiplies.

Parameters:
- WIDTH, 8, operand/modulus width in bits; legal range 4..64.

Ports:
- clk    input   1      system clock, rising edge.
- rst    input   1      reset, asynchronous, active-high.
- ena    input   1      clock enable; all state holds when low.
- clear  input   1      synchronous abort to IDLE.
- start  input   1      request; sampled only in IDLE with ena=1.
- A      input   WIDTH  multiplicand; captured on start.
- B      input   WIDTH  multiplier; captured on start.
- M      input   WIDTH  modulus; captured on start; must be odd.
- busy   output  1      high while an operation is in flight.
- done   output  1      one-cycle pulse when R is updated.
- err    output  1      operand-check failure pulse (see Optional Feature).
- R      output  WIDTH  result register.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, err=0, R=0; all internal registers 0.
- ena=0: every register holds, including done/err (pulses stretch). The latency below counts only cycles with ena=1.
- Internal state:
  - a_sh (WIDTH bits), b_q and m_q (WIDTH bits each).
  - acc (WIDTH+1 bits); the intermediate sum is WIDTH+2 bits and cannot overflow.
  - iteration counter, clog2(WIDTH+1) bits.
- IDLE:
  - On start=1, capture A/B/M, set acc=0 and cnt=0, go to CALC.
  - busy=1 from that edge.
  - done/err are cleared on any enabled edge on which they are not being set.
- CALC, one iteration per enabled edge:
  - ai = a_sh[0]
  - q = acc[0] ^ (ai & b_q[0])
  - acc = (acc + ai*b_q + q*m_q) >> 1
  - a_sh >>= 1; cnt++
  - After WIDTH iterations, go to SUB.
- SUB, one edge:
  - R = (acc >= m_q) ? acc - m_q : acc (truncated to WIDTH bits).
  - done=1, busy=0, state=IDLE.
- Latency: start sampled at edge t gives done high after edge t+WIDTH+1.
- Back-to-back: start is accepted on the edge where done=1 is visible.
- start outside IDLE is ignored; there is no queueing.
- R holds its value until the next done. Input changes after capture have no effect.
- clear=1 (ena=1):
  - Next edge: state=IDLE, busy=0, done=0, err=0, acc=0, cnt=0; R unchanged.
  - clear has priority over start on the same edge.
- rst mid-operation: immediate return to the reset values.
- Preconditions for a correct result: M odd, A<M, B<M. Under these, acc stays < 2M throughout and the final R is < M.

Optional Feature:
- Macro: MMM_ERR_CHECK_EN.
- Enabled: on an accepted start, check M[0]==0, A>=M or B>=M.
  - If any check fails, no CALC is entered.
  - Next enabled edge: err=1 and done=1 for one cycle, busy stays 0, R unchanged, state stays IDLE.
  - Valid operands behave exactly as without the macro.
- Disabled: err tied to 0 and no checks are made. Invalid operands run the normal WIDTH+1-cycle sequence. R is the deterministic algorithm output truncated to WIDTH bits; it is not guaranteed < M.

Test Plan:
- WIDTH=8, M=13, A=7, B=5, start for one cycle:
  - done exactly 9 cycles later, R=1, busy high for those 9 cycles.
  - Also A=1, B=1 gives R=3; A=0, B=9 gives R=0.
- WIDTH=8, boundary values exercising the final subtraction:
  - M=255, A=254, B=254 gives R=1.
  - M=251, A=250, B=250 gives R=201.
- Back-to-back: second start (M=13, A=1, B=1) on the done cycle of the first (A=7, B=5):
  - R=1, then R=3 nine cycles later.
  - A start pulsed mid-operation is ignored.
- ena stall: ena=0 for 3 cycles during CALC of M=13, A=7, B=5:
  - done after 12 cycles, R=1.
  - done held while ena=0 across it.
- clear at cycle 4 of an operation (M=13, A=7, B=5, R previously 3):
  - busy=0 next cycle, no done, R stays 3.
  - rst mid-CALC zeroes R/busy/done immediately.
- With MMM_ERR_CHECK_EN, M=12, A=1, B=1:
  - err=1 and done=1 one cycle after start, R unchanged.
  - Without the macro, the same stimulus gives err=0 and done after 9 cycles.
